// File: rtl/score_bcd_counter.sv
// Saturating multi-digit BCD game score with high-score register and new-record flag.
// Optional LEAD_BLANK_EN: leading zero digits on both output buses render as 4'hA (dash).
module score_bcd_counter #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hit,
  input  logic                  miss,
  input  logic                  clear,
  input  logic                  enable,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   hiscore_bcd,
  output logic                  new_record
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] score_q;
  logic [W-1:0] hiscore_q;
  logic         new_record_q;
  logic         hit_q;
  logic         miss_q;
  logic         en_q;

  logic         hit_ev;
  logic         miss_ev;
  logic         end_ev;

  logic [W-1:0] score_inc;
  logic [W-1:0] score_dec;
  logic         all_nines;
  logic         is_zero;
  logic         carry;
  logic         borrow;
  logic [3:0]   dig;

  assign hit_ev  = hit & ~hit_q;
  assign miss_ev = miss & ~miss_q;
  assign end_ev  = en_q & ~enable;

  // Per-digit ripple increment/decrement plus saturation/floor detection.
  always_comb begin
    score_inc = score_q;
    score_dec = score_q;
    carry     = 1'b1;
    borrow    = 1'b1;
    all_nines = 1'b1;
    is_zero   = 1'b1;
    dig       = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = score_q[4*i +: 4];
      if (dig != 4'd9) all_nines = 1'b0;
      if (dig != 4'd0) is_zero = 1'b0;
      if (carry) begin
        if (dig == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = 4'(dig + 4'd1);
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (dig == 4'd0) begin
          score_dec[4*i +: 4] = 4'd9;
        end else begin
          score_dec[4*i +: 4] = 4'(dig - 4'd1);
          borrow = 1'b0;
        end
      end
    end
  end

  // Event edge registers, score, high score and record flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      en_q         <= 1'b0;
      score_q      <= '0;
      hiscore_q    <= '0;
      new_record_q <= 1'b0;
    end else begin
      hit_q  <= hit;
      miss_q <= miss;
      en_q   <= enable;
      if (clear) begin
        score_q      <= '0;
        new_record_q <= 1'b0;
      end else if (end_ev) begin
        // Packed BCD compares correctly as an unsigned binary number.
        if (score_q > hiscore_q) begin
          hiscore_q    <= score_q;
          new_record_q <= 1'b1;
        end else begin
          new_record_q <= 1'b0;
        end
      end else if (enable) begin
        if (hit_ev && !miss_ev && !all_nines) begin
          score_q <= score_inc;
        end else if (miss_ev && !hit_ev && !is_zero) begin
          score_q <= score_dec;
        end
      end
    end
  end

  assign new_record = new_record_q;

`ifdef LEAD_BLANK_EN
  // Replace leading zero digits with a dash code; digit 0 always shows.
  function automatic logic [W-1:0] lead_blank(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         lead;
    r    = v;
    lead = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = 4'hA;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  assign score_bcd   = lead_blank(score_q);
  assign hiscore_bcd = lead_blank(hiscore_q);
`else
  assign score_bcd   = score_q;
  assign hiscore_bcd = hiscore_q;
`endif

endmodule

// File: tb/tb_score_bcd_counter.sv
// Scoreboard bench for score_bcd_counter (DIGITS=2): the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_score_bcd_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] score_bcd;
  logic [7:0] hiscore_bcd;
  logic       new_record;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int nid = 0;

  int         q_cyc[$];
  int         q_id[$];
  logic [7:0] q_s[$];
  logic [7:0] q_h[$];
  logic       q_n[$];

  score_bcd_counter #(.DIGITS(2)) dut (
    .clk(clk), .rst(rst), .hit(hit), .miss(miss), .clear(clear), .enable(enable),
    .score_bcd(score_bcd), .hiscore_bcd(hiscore_bcd), .new_record(new_record)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] disp(input logic [7:0] v);
`ifdef LEAD_BLANK_EN
    if (v[7:4] == 4'd0) return {4'hA, v[3:0]};
`endif
    return v;
  endfunction

  function automatic logic [7:0] bcd(input int k);
    return {4'(k / 10), 4'(k % 10)};
  endfunction

  task automatic step(input logic [7:0] s, input logic [7:0] h, input logic n);
    q_cyc.push_back(cyc + 1);
    q_id.push_back(nid);
    q_s.push_back(s);
    q_h.push_back(h);
    q_n.push_back(n);
    nid++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] s, input logic [7:0] h, input logic n);
    hit = 1'b1;
    step(s, h, n);
    hit = 1'b0;
    step(s, h, n);
  endtask

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    int c, id;
    logic [7:0] es, eh;
    logic en;
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      c  = q_cyc.pop_front();
      id = q_id.pop_front();
      es = disp(q_s.pop_front());
      eh = disp(q_h.pop_front());
      en = q_n.pop_front();
      total++;
      if (c != cyc || score_bcd !== es || hiscore_bcd !== eh || new_record !== en) begin
        bad++;
        $display("FAIL chk%0d cyc=%0d: got score=%h hi=%h rec=%b, required score=%h hi=%h rec=%b",
                 id, cyc, score_bcd, hiscore_bcd, new_record, es, eh, en);
      end
    end
  end

  initial begin
    // Reset state
    rst = 1'b1;
    step(8'h00, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    enable = 1'b1;
    step(8'h00, 8'h00, 1'b0);

    // Twelve hit pulses, each visible one cycle after the pulse
    for (int k = 1; k <= 12; k++) pulse(bcd(k), 8'h00, 1'b0);
    total++;
    if (score_bcd !== disp(8'h12)) begin
      bad++;
      $display("FAIL direct: after 12 hits score=%h, required %h", score_bcd, disp(8'h12));
    end
    // Up to saturation, then one more hit is ignored
    for (int k = 13; k <= 99; k++) pulse(bcd(k), 8'h00, 1'b0);
    pulse(8'h99, 8'h00, 1'b0);
    total++;
    if (score_bcd !== 8'h99) begin
      bad++;
      $display("FAIL direct: saturation score=%h, required 99", score_bcd);
    end

    // Clear, then a miss at zero is ignored
    clear = 1'b1;
    step(8'h00, 8'h00, 1'b0);
    clear = 1'b0;
    miss = 1'b1;
    step(8'h00, 8'h00, 1'b0);
    miss = 1'b0;
    step(8'h00, 8'h00, 1'b0);
    total++;
    if (score_bcd !== disp(8'h00)) begin
      bad++;
      $display("FAIL direct: floor score=%h, required %h", score_bcd, disp(8'h00));
    end

    // 10 -> 09 borrow, then a held hit counts once
    for (int k = 1; k <= 10; k++) pulse(bcd(k), 8'h00, 1'b0);
    miss = 1'b1;
    step(8'h09, 8'h00, 1'b0);
    miss = 1'b0;
    step(8'h09, 8'h00, 1'b0);
    hit = 1'b1;
    step(8'h10, 8'h00, 1'b0);
    repeat (19) step(8'h10, 8'h00, 1'b0);
    hit = 1'b0;
    step(8'h10, 8'h00, 1'b0);
    total++;
    if (score_bcd !== disp(8'h10)) begin
      bad++;
      $display("FAIL direct: held hit score=%h, required %h", score_bcd, disp(8'h10));
    end

    // Simultaneous hit and miss at 05
    clear = 1'b1;
    step(8'h00, 8'h00, 1'b0);
    clear = 1'b0;
    for (int k = 1; k <= 5; k++) pulse(bcd(k), 8'h00, 1'b0);
    hit = 1'b1;
    miss = 1'b1;
    step(8'h05, 8'h00, 1'b0);
    hit = 1'b0;
    miss = 1'b0;
    step(8'h05, 8'h00, 1'b0);
    total++;
    if (score_bcd !== disp(8'h05)) begin
      bad++;
      $display("FAIL direct: hit+miss score=%h, required %h", score_bcd, disp(8'h05));
    end

    // First game ends at 25: record
    clear = 1'b1;
    step(8'h00, 8'h00, 1'b0);
    clear = 1'b0;
    for (int k = 1; k <= 25; k++) pulse(bcd(k), 8'h00, 1'b0);
    enable = 1'b0;
    step(8'h25, 8'h25, 1'b1);
    step(8'h25, 8'h25, 1'b1);
    pulse(8'h25, 8'h25, 1'b1);

    // Second game ends at 37 with a hit in the end cycle (ignored)
    clear = 1'b1;
    step(8'h00, 8'h25, 1'b0);
    clear = 1'b0;
    enable = 1'b1;
    step(8'h00, 8'h25, 1'b0);
    for (int k = 1; k <= 37; k++) pulse(bcd(k), 8'h25, 1'b0);
    hit = 1'b1;
    enable = 1'b0;
    step(8'h37, 8'h37, 1'b1);
    hit = 1'b0;
    step(8'h37, 8'h37, 1'b1);
    total++;
    if (hiscore_bcd !== 8'h37 || new_record !== 1'b1) begin
      bad++;
      $display("FAIL direct: record hi=%h rec=%b, required 37/1", hiscore_bcd, new_record);
    end

    // Third game ends at 20: no record
    clear = 1'b1;
    step(8'h00, 8'h37, 1'b0);
    clear = 1'b0;
    enable = 1'b1;
    step(8'h00, 8'h37, 1'b0);
    for (int k = 1; k <= 20; k++) pulse(bcd(k), 8'h37, 1'b0);
    enable = 1'b0;
    step(8'h20, 8'h37, 1'b0);
    total++;
    if (hiscore_bcd !== 8'h37 || new_record !== 1'b0) begin
      bad++;
      $display("FAIL direct: no record hi=%h rec=%b, required 37/0", hiscore_bcd, new_record);
    end

    // Reset mid-game with hit held through release: counts once
    enable = 1'b1;
    step(8'h20, 8'h37, 1'b0);
    hit = 1'b1;
    rst = 1'b1;
    step(8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    step(8'h01, 8'h00, 1'b0);
    step(8'h01, 8'h00, 1'b0);
    hit = 1'b0;
    step(8'h01, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    while (q_cyc.size() > 0) begin
      void'(q_cyc.pop_front());
      total++;
      bad++;
      $display("FAIL chk%0d never compared", q_id.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
